// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a requester and the PS/2 host transmitter.
`timescale 1ns/1ps
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (output tx_data, tx_valid, input tx_ready, busy, tx_done, tx_error);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, tx_done, tx_error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter on open-drain CLK/DAT pull-low enables.
// Define PS2_TX_RETRY_EN to resend the latched byte once after a device NACK.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int CLK_INHIBIT_CYCLES = 6000,
  parameter int REQ_SETUP_CYCLES   = 64,
  parameter int FILTER_LEN         = 8,
  parameter int TIMEOUT_CYCLES     = 1000000
) (
  input  logic         CLOCK_50,
  input  logic         rst_n,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam int CNT_MAX = (CLK_INHIBIT_CYCLES > REQ_SETUP_CYCLES) ? CLK_INHIBIT_CYCLES
                                                                   : REQ_SETUP_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   tmo;
  logic [3:0]      bit_idx;
  logic            ready;
  logic            done;
  logic            err;
  logic [10:0]     frame;
  logic [10:0]     reload_frame;
  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] clk_sh;
  logic            clk_filt, clk_filt_prev;
  logic            fall, accept, tmo_hit, shift, ack_fall, reload;

  // Frame is sent LSB first: start, data[7:0], odd parity, stop.
  function automatic logic [10:0] build_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1        <= 1'b1;
      clk_s2        <= 1'b1;
      dat_s1        <= 1'b1;
      dat_s2        <= 1'b1;
      clk_sh        <= {FILTER_LEN{1'b1}};
      clk_filt      <= 1'b1;
      clk_filt_prev <= 1'b1;
    end else begin
      clk_s1        <= ps2_clk_in;
      clk_s2        <= clk_s1;
      dat_s1        <= ps2_dat_in;
      dat_s2        <= dat_s1;
      clk_sh        <= {clk_sh[FILTER_LEN-2:0], clk_s2};
      if (&clk_sh)
        clk_filt <= 1'b1;
      else if (~|clk_sh)
        clk_filt <= 1'b0;
      clk_filt_prev <= clk_filt;
    end
  end

  assign fall     = clk_filt_prev & ~clk_filt;
  assign accept   = bus.tx_valid & ready;
  assign tmo_hit  = (state inside {SEND, ACK, WAIT_IDLE}) && (tmo == TMO_LAST);
  assign shift    = (state == SEND) & fall & ~tmo_hit;
  assign ack_fall = (state == ACK) & fall & ~tmo_hit;

`ifdef PS2_TX_RETRY_EN
  logic       retried;
  logic [7:0] tx_byte;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)
      retried <= 1'b0;
    else if (accept)
      retried <= 1'b0;
    else if (reload)
      retried <= 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (accept)
      tx_byte <= bus.tx_data;
  end

  assign reload       = ack_fall & dat_s2 & ~retried;
  assign reload_frame = build_frame(tx_byte);
`else
  assign reload       = 1'b0;
  assign reload_frame = 11'h7ff;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (accept)
      frame <= build_frame(bus.tx_data);
    else if (reload)
      frame <= reload_frame;
    else if (shift)
      frame <= {1'b1, frame[10:1]};
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      tmo        <= '0;
      bit_idx    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state inside {SEND, ACK, WAIT_IDLE})
        tmo <= tmo + 1'b1;
      // A timeout abandons the transfer even if a clock fall arrives the same cycle.
      if (tmo_hit) begin
        state      <= IDLE;
        tmo        <= '0;
        bit_idx    <= '0;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        ready      <= 1'b1;
        err        <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state      <= INHIBIT;
              cnt        <= '0;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
              ready      <= 1'b0;
            end
          end
          INHIBIT: begin
            if (cnt == INH_LAST) begin
              state      <= REQUEST;
              cnt        <= '0;
              ps2_dat_oe <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REQUEST: begin
            if (cnt == REQ_LAST) begin
              state      <= SEND;
              cnt        <= '0;
              tmo        <= '0;
              bit_idx    <= '0;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= ~frame[0];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SEND: begin
            if (fall) begin
              bit_idx    <= bit_idx + 1'b1;
              ps2_dat_oe <= ~frame[1];
              if (bit_idx == 4'd9) begin
                state      <= ACK;
                ps2_dat_oe <= 1'b0;
              end
            end
          end
          ACK: begin
            if (fall) begin
              if (!dat_s2) begin
                state <= WAIT_IDLE;
              end else if (reload) begin
                state      <= INHIBIT;
                cnt        <= '0;
                ps2_clk_oe <= 1'b1;
              end else begin
                state <= IDLE;
                ready <= 1'b1;
                err   <= 1'b1;
              end
            end
          end
          WAIT_IDLE: begin
            if (clk_filt && dat_s2) begin
              state <= IDLE;
              ready <= 1'b1;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tx_ready = ready;
  assign bus.busy     = ~ready;
  assign bus.tx_done  = done;
  assign bus.tx_error = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a behavioural open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH  = 6000;
  localparam int REQ  = 64;
  localparam int TMO  = 2000;
  localparam int HALF = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();
  logic ps2_clk_oe, ps2_dat_oe;
  logic dev_clk = 1'b0;
  logic dev_dat = 1'b0;
  logic clk_line, dat_line;
  assign clk_line = ~(ps2_clk_oe | dev_clk);
  assign dat_line = ~(ps2_dat_oe | dev_dat);

  ps2_host_tx #(
    .CLK_INHIBIT_CYCLES(INH),
    .REQ_SETUP_CYCLES(REQ),
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50(clk),
    .rst_n(rst_n),
    .bus(bus),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_err = 0, n_both = 0;
  int inh_run = 0, inh_last = 0, inh_cnt = 0;
  int req_run = 0, req_last = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected bits on falls 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] ref_bits(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2) == 0;
    return {1'b1, par, b};
  endfunction

  always @(negedge clk) begin
    if (ps2_clk_oe && !ps2_dat_oe) inh_run <= inh_run + 1;
    else if (inh_run != 0) begin
      inh_last <= inh_run;
      inh_run  <= 0;
      inh_cnt  <= inh_cnt + 1;
    end
    if (ps2_clk_oe && ps2_dat_oe) req_run <= req_run + 1;
    else if (req_run != 0) begin
      req_last <= req_run;
      req_run  <= 0;
    end
    if (bus.tx_done) n_done <= n_done + 1;
    if (bus.tx_error) n_err <= n_err + 1;
    if (bus.tx_done && bus.tx_error) n_both <= n_both + 1;
  end

  task automatic send(input logic [7:0] b, input bit junk);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    check("accept_ready", bus.tx_ready, 1'b0);
    check("accept_busy", bus.busy, 1'b1);
    if (junk) begin
      for (int i = 0; i < 50; i++) begin
        bus.tx_data = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  task automatic device(input logic [7:0] b, input bit ack, input bit glitch, input int nfalls);
    logic [9:0] bits = '0;
    int n = 0;
    while (!(clk_line && !dat_line) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("rts_seen", n < 10000, 1'b1);
    if (n >= 10000) return;
    check("start_bit_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
    repeat (40) @(negedge clk);
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11) dev_dat = ack;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      if (i <= 10) bits[i-1] = dat_line;
      if (glitch && i < 11) begin
        repeat (15) @(negedge clk);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF - 18) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_dat = 1'b0;
    if (nfalls >= 10) check("frame_bits", bits, ref_bits(b));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ready_return", n < 3000, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] b, input bit junk, input bit glitch);
    int d0, e0, i0;
    d0 = n_done; e0 = n_err; i0 = inh_cnt;
    send(b, junk);
    device(b, 1'b1, glitch, 11);
    wait_ready();
    check("done_count", n_done - d0, 1);
    check("error_count", n_err - e0, 0);
    check("ready_idle", {bus.tx_ready, bus.busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
    check("inhibit_len", inh_last, INH);
    check("request_len", req_last, REQ);
    check("inhibit_phases", inh_cnt - i0, 1);
  endtask

  initial begin
    logic [7:0] b;
    int d0, e0, i0, n;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ps2_clk_oe, ps2_dat_oe, bus.tx_ready, bus.busy, bus.tx_done, bus.tx_error},
          6'b001000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    xfer(8'hED, 1'b0, 1'b0);
    xfer(8'hFF, 1'b1, 1'b0);

    // Device NACK
    b = 8'($urandom_range(0, 255));
    d0 = n_done; e0 = n_err; i0 = inh_cnt;
    send(b, 1'b0);
    device(b, 1'b0, 1'b0, 11);
`ifdef PS2_TX_RETRY_EN
    check("retry_busy", bus.busy, 1'b1);
    check("retry_no_error", n_err - e0, 0);
    device(b, 1'b1, 1'b0, 11);
    wait_ready();
    check("retry_done", n_done - d0, 1);
    check("retry_error", n_err - e0, 0);
    check("retry_phases", inh_cnt - i0, 2);
    check("retry_inhibit_len", inh_last, INH);
`else
    wait_ready();
    check("nack_done", n_done - d0, 0);
    check("nack_error", n_err - e0, 1);
`endif

    // Device never clocks
    b = 8'($urandom_range(0, 255));
    d0 = n_done; e0 = n_err;
    send(b, 1'b0);
    n = 0;
    while (!(!ps2_clk_oe && ps2_dat_oe) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("release_seen", n < 10000, 1'b1);
    n = 0;
    while (!bus.tx_error && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    wait_ready();
    check("timeout_error", n_err - e0, 1);
    check("timeout_done", n_done - d0, 0);

    xfer(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    for (int k = 0; k < 2; k++)
      xfer(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset in the middle of the data bits
    send(8'h0F, 1'b0);
    device(8'h0F, 1'b1, 1'b0, 5);
    check("pre_reset_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
    #2 rst_n = 1'b0;
    #1 check("async_reset_lines", {ps2_clk_oe, ps2_dat_oe, bus.tx_ready, bus.busy}, 4'b0010);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_ready", bus.tx_ready, 1'b1);
    xfer(8'h55, 1'b0, 1'b0);

    check("done_error_overlap", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
